// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial transpose link: FSM states, bank
// access encoding and package length / parity functions.
package serial_link_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTxRd,
    StTxSh,
    StTxGap,
    StRxCol,
    StRxWr,
    StDone
  } state_e;

  localparam logic RB_READ  = 1'b1;
  localparam logic RB_WRITE = 1'b0;

  function automatic int unsigned pkt_len_tx(input int unsigned idx_w,
                                             input int unsigned depth,
                                             input int unsigned parity);
    return idx_w + depth + parity;
  endfunction

  function automatic int unsigned pkt_len_rx(input int unsigned aw,
                                             input int unsigned dw,
                                             input int unsigned parity);
    return aw + dw + parity;
  endfunction

  // Callers zero-extend narrower vectors; zeros leave the parity unchanged.
  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sd_deser_rx.sv
// Receive-side deserialiser: shifts in sd while sen is low, counts bits and
// classifies each package as good or bad at the first sen-high cycle.
module sd_deser_rx
  import serial_link_pkg::*;
#(
  parameter int unsigned AW     = 3,
  parameter int unsigned DW     = 18,
  parameter int unsigned PARITY = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          sen_i,
  input  logic          sd_i,
  output logic          pkt_ok_o,
  output logic          pkt_bad_o,
  output logic [AW-1:0] pkt_addr_o,
  output logic [DW-1:0] pkt_data_o
);

  localparam int unsigned LR = pkt_len_rx(AW, DW, PARITY);
  localparam int unsigned CW = $clog2(LR + 2);

  logic [LR-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pkt_end, len_ok, par_ok;

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    pkt_end = en_i & sen_i & (cnt_q != '0);
    len_ok  = (cnt_q == CW'(LR));
    par_ok  = (PARITY == 0) || !even_par(64'(sr_q));
    if (!en_i || sen_i) begin
      cnt_d = '0;
    end else begin
      sr_d = {sr_q[LR-2:0], sd_i};
      // Saturate one past LR so over-long packages stay distinguishable.
      if (cnt_q != CW'(LR + 1)) cnt_d = cnt_q + 1'b1;
    end
  end

  assign pkt_ok_o   = pkt_end & len_ok & par_ok;
  assign pkt_bad_o  = pkt_end & ~(len_ok & par_ok);
  assign pkt_addr_o = sr_q[LR-1 -: AW];
  assign pkt_data_o = sr_q[LR-1-AW -: DW];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_xpose_link.sv
// Bidirectional serial endpoint: TX reads and transposes the register bank into
// one package per data-bit column; RX buffers address+data packages then burst-writes the bank.
module serial_xpose_link
  import serial_link_pkg::*;
#(
  parameter int unsigned DW     = 18,
  parameter int unsigned AW     = 3,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned PARITY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rb_rw,
  output logic [AW-1:0] rb_a,
  output logic [DW-1:0] rb_d,
  input  logic [DW-1:0] rb_q,
  inout  wire           sen,
  inout  wire           sd
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned LT    = pkt_len_tx(IDX_W, DEPTH, PARITY);
  localparam int unsigned CW    = $clog2(DEPTH + LT + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [AW-1:0]      rb_a_q, rb_a_d;
  logic               err_q, err_d;
  logic [DW-1:0]      buf_q [DEPTH];
  logic [DW-1:0]      buf_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;

  logic               pkt_ok, pkt_bad;
  logic [AW-1:0]      pkt_addr;
  logic [DW-1:0]      pkt_data;

  logic [DEPTH-1:0]   col;
  logic [LT-1:0]      tx_word, tx_shift;
  logic               sen_oe, sen_o, sd_oe, sd_o;

  sd_deser_rx #(
    .AW     (AW),
    .DW     (DW),
    .PARITY (PARITY)
  ) u_deser (
    .clk_i      (clk),
    .rst_ni     (rst),
    .en_i       (state_q == StRxCol),
    .sen_i      (sen),
    .sd_i       (sd),
    .pkt_ok_o   (pkt_ok),
    .pkt_bad_o  (pkt_bad),
    .pkt_addr_o (pkt_addr),
    .pkt_data_o (pkt_data)
  );

  // Column k of the buffer: bit k of every word, word DEPTH-1 in the MSB.
  always_comb begin
    logic [DW-1:0] w;
    col = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w      = buf_q[i] >> k_q;
      col[i] = w[0];
    end
  end

  if (PARITY != 0) begin : g_par
    assign tx_word = {k_q, col, even_par(64'({k_q, col}))};
  end else begin : g_nopar
    assign tx_word = {k_q, col};
  end

  assign tx_shift = tx_word << cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    rb_a_d  = rb_a_q;
    err_d   = err_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d   = 1'b0;
          valid_d = '0;
          cnt_d   = '0;
          k_d     = '0;
          if (mode) begin
            state_d = StTxRd;
            rb_a_d  = '0;
          end else begin
            state_d = StRxCol;
          end
        end
      end
      StTxRd: begin
        // rb_q reflects the address presented on the previous cycle.
        if (cnt_q != '0) buf_d[AW'(cnt_q - 1'b1)] = rb_q;
        if (cnt_q == CW'(DEPTH)) begin
          state_d = StTxSh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q < CW'(DEPTH - 1)) rb_a_d = AW'(cnt_q + 1'b1);
        end
      end
      StTxSh: begin
        if (cnt_q == CW'(LT - 1)) begin
          state_d = StTxGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTxGap: begin
        if (k_q == IDX_W'(DW - 1)) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = StTxSh;
        end
      end
      StRxCol: begin
        if (pkt_ok) begin
          buf_d[pkt_addr]   = pkt_data;
          valid_d[pkt_addr] = 1'b1;
        end
        if (pkt_bad) err_d = 1'b1;
        if (&valid_q) begin
          state_d = StRxWr;
          cnt_d   = '0;
          rb_a_d  = '0;
        end
      end
      StRxWr: begin
        if (cnt_q == CW'(DEPTH - 1)) begin
          state_d = StDone;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          rb_a_d = AW'(cnt_q + 1'b1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      k_q     <= '0;
      rb_a_q  <= '0;
      err_q   <= 1'b0;
      buf_q   <= '{default: '0};
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      rb_a_q  <= rb_a_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    err    = err_q;
    rb_rw  = (state_q == StRxWr) ? RB_WRITE : RB_READ;
    rb_a   = rb_a_q;
    rb_d   = (state_q == StRxWr) ? buf_q[rb_a_q] : '0;
    sen_oe = (state_q == StTxSh) || (state_q == StTxGap);
    sen_o  = (state_q == StTxGap);
    sd_oe  = (state_q == StTxSh);
    sd_o   = tx_shift[LT-1];
  end

  assign sen = sen_oe ? sen_o : 1'bz;
  assign sd  = sd_oe ? sd_o : 1'bz;

endmodule

// File: tb/tb_serial_xpose_link.sv
// Directed bench for serial_xpose_link: default 8x18 instance and a DW=8/AW=2/no-parity
// instance, each with a one-cycle-latency bank model and pulled-up link nets.
module tb_serial_xpose_link;

  logic clk, rst, start, mode, sel, bank_init, tb_oe, tb_sen, tb_sd;
  logic busy_b, done_b, err_b, rw_b, busy_s, done_s, err_s, rw_s;
  logic [2:0]  a_b;
  logic [1:0]  a_s;
  logic [17:0] d_b, q_b;
  logic [7:0]  d_s, q_s;
  wire sen_b, sd_b, sen_s, sd_s;

  logic [17:0] mem_b [8];
  logic [7:0]  mem_s [4];
  logic [17:0] exp_wr [8];

  logic o_busy, o_done, o_err, o_rw, o_sen, o_sd;
  logic [2:0]  o_a;
  logic [17:0] o_d;

  int checks, errors;
  int n_dw, n_aw, n_depth, n_lt, n_par;

  pullup (sen_b);
  pullup (sd_b);
  pullup (sen_s);
  pullup (sd_s);

  assign sen_b = (tb_oe && !sel) ? tb_sen : 1'bz;
  assign sd_b  = (tb_oe && !sel) ? tb_sd  : 1'bz;
  assign sen_s = (tb_oe && sel)  ? tb_sen : 1'bz;
  assign sd_s  = (tb_oe && sel)  ? tb_sd  : 1'bz;

  serial_xpose_link u_big (
    .clk   (clk),
    .rst   (rst),
    .start (start & ~sel),
    .mode  (mode),
    .busy  (busy_b),
    .done  (done_b),
    .err   (err_b),
    .rb_rw (rw_b),
    .rb_a  (a_b),
    .rb_d  (d_b),
    .rb_q  (q_b),
    .sen   (sen_b),
    .sd    (sd_b)
  );

  serial_xpose_link #(
    .DW     (8),
    .AW     (2),
    .IDX_W  (5),
    .PARITY (0)
  ) u_small (
    .clk   (clk),
    .rst   (rst),
    .start (start & sel),
    .mode  (mode),
    .busy  (busy_s),
    .done  (done_s),
    .err   (err_s),
    .rb_rw (rw_s),
    .rb_a  (a_s),
    .rb_d  (d_s),
    .rb_q  (q_s),
    .sen   (sen_s),
    .sd    (sd_s)
  );

  always_ff @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 8; i++) mem_b[i] <= 18'h3FFFF >> i;
      for (int i = 0; i < 4; i++) mem_s[i] <= 8'hFF >> i;
    end else begin
      if (!rw_b) mem_b[a_b] <= d_b;
      if (!rw_s) mem_s[a_s] <= d_s;
    end
    q_b <= mem_b[a_b];
    q_s <= mem_s[a_s];
  end

  always_comb begin
    o_busy = sel ? busy_s : busy_b;
    o_done = sel ? done_s : done_b;
    o_err  = sel ? err_s  : err_b;
    o_rw   = sel ? rw_s   : rw_b;
    o_sen  = sel ? sen_s  : sen_b;
    o_sd   = sel ? sd_s   : sd_b;
    o_a    = sel ? {1'b0, a_s} : a_b;
    o_d    = sel ? {10'b0, d_s} : d_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_pkt(input int k);
    logic [31:0] v;
    logic p, bt;
    v = '0;
    p = 1'b0;
    for (int b = 4; b >= 0; b--) begin
      bt = k[b];
      v  = {v[30:0], bt};
      p  = p ^ bt;
    end
    for (int i = n_depth - 1; i >= 0; i--) begin
      if (sel) bt = mem_s[i][k];
      else     bt = mem_b[i][k];
      v = {v[30:0], bt};
      p = p ^ bt;
    end
    if (n_par != 0) v = {v[30:0], p};
    return v;
  endfunction

  function automatic logic [31:0] mk_rx(input int addr, input int data, input bit flip);
    logic [31:0] v;
    logic p, bt;
    v = '0;
    p = 1'b0;
    for (int b = n_aw - 1; b >= 0; b--) begin
      bt = addr[b];
      v  = {v[30:0], bt};
      p  = p ^ bt;
    end
    for (int b = n_dw - 1; b >= 0; b--) begin
      bt = data[b];
      v  = {v[30:0], bt};
      p  = p ^ bt;
    end
    if (n_par != 0) v = {v[30:0], p ^ flip};
    return v;
  endfunction

  task automatic send_pkt(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      tb_oe  = 1'b1;
      tb_sen = 1'b0;
      tb_sd  = bits[i];
      tick();
    end
    tb_sen = 1'b1;
    tb_sd  = 1'b0;
    tick();
  endtask

  task automatic tx_run(input string tn, input logic [31:0] pk0_exp);
    logic [31:0] pk;
    bit ok, frm;
    start = 1'b1;
    mode  = 1'b1;
    tick();
    start = 1'b0;
    chk({tn, " busy rise"}, 32'(o_busy), 1);
    ok = (o_a == 3'd0) && (o_rw === 1'b1);
    for (int c = 1; c <= n_depth; c++) begin
      tick();
      if (int'(o_a) != ((c < n_depth) ? c : n_depth - 1) || o_rw !== 1'b1 || o_busy !== 1'b1)
        ok = 0;
    end
    chk({tn, " read sweep"}, 32'(ok), 1);
    frm = 1;
    for (int k = 0; k < n_dw; k++) begin
      pk = '0;
      for (int b = 0; b < n_lt; b++) begin
        tick();
        pk = {pk[30:0], o_sd};
        if (o_sen !== 1'b0 || o_done !== 1'b0) frm = 0;
      end
      if (k == 0) chk({tn, " pkg0 literal"}, pk, pk0_exp);
      chk($sformatf("%s pkg%0d", tn, k), pk, exp_pkt(k));
      tick();
      if (o_sen !== 1'b1 || o_sd !== 1'b1 || o_done !== 1'b0) frm = 0;
    end
    chk({tn, " framing and gaps"}, 32'(frm), 1);
    tick();
    chk({tn, " done at cycle"}, 32'(o_done), 1);
    tick();
    chk({tn, " busy fall"}, 32'(o_busy), 0);
    chk({tn, " done pulse"}, 32'(o_done), 0);
  endtask

  task automatic rx_start(input string tn);
    start = 1'b1;
    mode  = 1'b0;
    tick();
    start = 1'b0;
    chk({tn, " rx busy"}, 32'(o_busy), 1);
    chk({tn, " err cleared"}, 32'(o_err), 0);
  endtask

  task automatic rx_burst(input string tn);
    int w;
    bit ok;
    w = 0;
    while (o_rw !== 1'b0 && w < 6) begin
      tick();
      w++;
    end
    chk({tn, " burst start"}, 32'(o_rw), 0);
    ok = 1;
    for (int i = 0; i < n_depth; i++) begin
      if (o_rw !== 1'b0 || int'(o_a) != i) ok = 0;
      chk($sformatf("%s wr%0d data", tn, i), 32'(o_d), 32'(exp_wr[i]));
      tick();
    end
    chk({tn, " burst addr seq"}, 32'(ok), 1);
    chk({tn, " rw back"}, 32'(o_rw), 1);
    chk({tn, " done"}, 32'(o_done), 1);
    tick();
    chk({tn, " idle"}, 32'(o_busy), 0);
    tb_oe = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    sel       = 1'b0;
    bank_init = 1'b1;
    tb_oe     = 1'b0;
    tb_sen    = 1'b1;
    tb_sd     = 1'b0;
    n_dw = 18; n_aw = 3; n_depth = 8; n_lt = 14; n_par = 1;
    tick();
    bank_init = 1'b0;
    chk("rst busy", 32'(o_busy), 0);
    chk("rst done", 32'(o_done), 0);
    chk("rst err", 32'(o_err), 0);
    chk("rst rb_rw", 32'(o_rw), 1);
    chk("rst rb_a", 32'(o_a), 0);
    chk("rst rb_d", 32'(o_d), 0);
    chk("rst sen released", 32'(o_sen), 1);
    tick();
    rst = 1'b1;
    tick();

    tx_run("t1", 32'h01FE);

    // Abort during package 5 (cycle 9 + 5*15 + 3 after busy rises).
    start = 1'b1;
    mode  = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 87; c++) tick();
    chk("t5 driving before reset", 32'(o_sen), 0);
    rst = 1'b0;
    #1;
    chk("t5 busy", 32'(o_busy), 0);
    chk("t5 sen released", 32'(o_sen), 1);
    chk("t5 sd released", 32'(o_sd), 1);
    chk("t5 rb_rw", 32'(o_rw), 1);
    chk("t5 rb_a", 32'(o_a), 0);
    tick();
    rst = 1'b1;
    tick();
    tx_run("t5 restart", 32'h01FE);

    rx_start("t2");
    for (int a = 7; a >= 0; a--) begin
      send_pkt(mk_rx(a, 'h1000 + a, 1'b0), 22);
      exp_wr[a] = 18'(32'h1000 + a);
    end
    rx_burst("t2");
    chk("t2 err", 32'(o_err), 0);

    rx_start("t3");
    for (int a = 0; a < 6; a++) begin
      send_pkt(mk_rx(a, 'h2000 + a, 1'b0), 22);
      exp_wr[a] = 18'(32'h2000 + a);
    end
    send_pkt(mk_rx(6, 'h2006, 1'b1), 22);
    chk("t3 err after parity", 32'(o_err), 1);
    send_pkt(mk_rx(7, 'h2007, 1'b0) >> 1, 21);
    tick();
    tick();
    chk("t3 no burst", 32'(o_rw), 1);
    chk("t3 still busy", 32'(o_busy), 1);
    send_pkt(mk_rx(6, 'h2006, 1'b0), 22);
    send_pkt(mk_rx(7, 'h2007, 1'b0), 22);
    exp_wr[6] = 18'h02006;
    exp_wr[7] = 18'h02007;
    rx_burst("t3");
    chk("t3 err sticky", 32'(o_err), 1);

    rx_start("t4");
    send_pkt(mk_rx(3, 'h00AAA, 1'b0), 22);
    send_pkt(mk_rx(3, 'h15555, 1'b0), 22);
    for (int a = 0; a < 8; a++) begin
      exp_wr[a] = 18'(32'h3000 + a);
      if (a != 3) send_pkt(mk_rx(a, 'h3000 + a, 1'b0), 22);
    end
    exp_wr[3] = 18'h15555;
    rx_burst("t4");

    sel = 1'b1;
    n_dw = 8; n_aw = 2; n_depth = 4; n_lt = 9; n_par = 0;
    tick();
    tx_run("t6 tx", 32'h000F);
    rx_start("t6");
    for (int a = 3; a >= 0; a--) begin
      send_pkt(mk_rx(a, 'h10 + a, 1'b0), 10);
      exp_wr[a] = 18'(32'h10 + a);
    end
    rx_burst("t6");
    chk("t6 err", 32'(o_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
